itlb_ptw: RTL and testbench

ITLB_PTW -- requirements
Module: itlb_ptw

---
 rtl/itlb_ptw_if.sv | 39 +++
 rtl/itlb_ptw.sv | 180 ++++++++++++++++++
 tb/tb_itlb_ptw.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itlb_ptw_if.sv
// Handshake bundle between the instruction page-table walker, the ITLB miss/refill
// ports and the PTE read port. slave = walker side, master = ITLB/memory side.
interface itlb_ptw_if;
   localparam int unsigned MXLEN = 32;
   localparam int unsigned PA_W  = 34;
   localparam int unsigned VPN_W = 20;

   logic             miss_valid_i;
   logic             miss_ready_o;
   logic [MXLEN-1:0] miss_vaddr_i;

   logic             mem_req_valid_o;
   logic             mem_req_ready_i;
   logic [PA_W-1:0]  mem_req_addr_o;

   logic             mem_rsp_valid_i;
   logic [MXLEN-1:0] mem_rsp_data_i;

   logic             refill_valid_o;
   logic             refill_ready_i;
   logic [VPN_W-1:0] refill_vpn_o;
   logic [MXLEN-1:0] refill_pte_o;
   logic             refill_level_o;
   logic             fault_o;

   modport slave (
      input  miss_valid_i, miss_vaddr_i, mem_req_ready_i, mem_rsp_valid_i,
             mem_rsp_data_i, refill_ready_i,
      output miss_ready_o, mem_req_valid_o, mem_req_addr_o, refill_valid_o,
             refill_vpn_o, refill_pte_o, refill_level_o, fault_o
   );

   modport master (
      output miss_valid_i, miss_vaddr_i, mem_req_ready_i, mem_rsp_valid_i,
             mem_rsp_data_i, refill_ready_i,
      input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, refill_valid_o,
             refill_vpn_o, refill_pte_o, refill_level_o, fault_o
   );
endinterface

// File: rtl/itlb_ptw.sv
// Sv32 instruction-side page-table walker: one miss at a time, two-level walk,
// leaf permission/alignment checks, flush abort with response draining.
module itlb_ptw #(
   localparam int unsigned MXLEN = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [MXLEN-1:0] satp_i,
   input  logic             flush_i,
   itlb_ptw_if.slave        bus_io
);
   localparam int unsigned PPN_W = 22;
   localparam int unsigned VPN_W = 20;
   localparam int unsigned SEG_W = 10;
   localparam int unsigned PA_W  = 34;

   typedef struct packed {
      logic             mode;
      logic [8:0]       asid;
      logic [PPN_W-1:0] ppn;
   } satp_t;

   typedef struct packed {
      logic [PPN_W-1:0] ppn;
      logic [1:0]       rsw;
      logic             d;
      logic             a;
      logic             g;
      logic             u;
      logic             x;
      logic             w;
      logic             r;
      logic             v;
   } pte_t;

   typedef enum logic [2:0] {
      IDLE, L1_REQ, L1_RSP, L0_REQ, L0_RSP, DONE, DRAIN
   } state_e;

   state_e           state_q, state_d;
   logic [VPN_W-1:0] vpn_q, vpn_d;
   logic [PPN_W-1:0] base_q, base_d;
   logic [MXLEN-1:0] pte_q, pte_d;
   logic             level_q, level_d;
   logic             fault_q, fault_d;

   satp_t satp;
   pte_t  rsp;
   logic  rsp_bad;
   logic  rsp_leaf;
   logic  miss_hs;
   logic  unused_bits;

   assign satp     = satp_t'(satp_i);
   assign rsp      = pte_t'(bus_io.mem_rsp_data_i);
   assign rsp_bad  = !rsp.v || (!rsp.r && rsp.w);
   assign rsp_leaf = rsp.r || rsp.x;
   assign miss_hs  = (state_q == IDLE) && !flush_i && bus_io.miss_valid_i;

   // Fields that never influence the walk.
   assign unused_bits = ^{satp.asid, rsp.rsw, rsp.d, rsp.a, rsp.g, rsp.u,
                          bus_io.miss_vaddr_i[11:0]};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         vpn_q   <= '0;
         base_q  <= '0;
         pte_q   <= '0;
         level_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         base_q  <= base_d;
         pte_q   <= pte_d;
         level_q <= level_d;
         fault_q <= fault_d;
      end
   end

   // base_q holds the root table PPN for level 1, then the level-0 table PPN.
   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      base_d  = base_q;
      pte_d   = pte_q;
      level_d = level_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: begin
            if (miss_hs) begin
               vpn_d   = bus_io.miss_vaddr_i[31:12];
               base_d  = satp.ppn;
               pte_d   = '0;
               level_d = 1'b0;
               fault_d = !satp.mode;
               state_d = satp.mode ? L1_REQ : DONE;
            end
         end
         L1_REQ, L0_REQ: begin
            if (flush_i) begin
               state_d = bus_io.mem_req_ready_i ? DRAIN : IDLE;
            end else if (bus_io.mem_req_ready_i) begin
               state_d = (state_q == L1_REQ) ? L1_RSP : L0_RSP;
            end
         end
         L1_RSP: begin
            if (flush_i) begin
               state_d = bus_io.mem_rsp_valid_i ? IDLE : DRAIN;
            end else if (bus_io.mem_rsp_valid_i) begin
               state_d = DONE;
               if (rsp_bad || (rsp_leaf && ((rsp.ppn[SEG_W-1:0] != '0) || !rsp.x))) begin
                  fault_d = 1'b1;
               end else if (rsp_leaf) begin
                  pte_d   = bus_io.mem_rsp_data_i;
                  level_d = 1'b1;
               end else begin
                  base_d  = rsp.ppn;
                  state_d = L0_REQ;
               end
            end
         end
         L0_RSP: begin
            if (flush_i) begin
               state_d = bus_io.mem_rsp_valid_i ? IDLE : DRAIN;
            end else if (bus_io.mem_rsp_valid_i) begin
               state_d = DONE;
               if (rsp_bad || !rsp_leaf || !rsp.x) begin
                  fault_d = 1'b1;
               end else begin
                  pte_d   = bus_io.mem_rsp_data_i;
                  level_d = 1'b0;
               end
            end
         end
         DONE: begin
            if (flush_i || bus_io.refill_ready_i) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (bus_io.mem_rsp_valid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode state and captured registers only; inactive fields read as zero.
   always_comb begin
      bus_io.miss_ready_o    = (state_q == IDLE) && !flush_i;
      bus_io.mem_req_valid_o = 1'b0;
      bus_io.mem_req_addr_o  = '0;
      bus_io.refill_valid_o  = 1'b0;
      bus_io.refill_vpn_o    = '0;
      bus_io.refill_pte_o    = '0;
      bus_io.refill_level_o  = 1'b0;
      bus_io.fault_o         = 1'b0;
      unique case (state_q)
         L1_REQ: begin
            bus_io.mem_req_valid_o = 1'b1;
            bus_io.mem_req_addr_o  = PA_W'({base_q, vpn_q[VPN_W-1:SEG_W], 2'b00});
         end
         L0_REQ: begin
            bus_io.mem_req_valid_o = 1'b1;
            bus_io.mem_req_addr_o  = PA_W'({base_q, vpn_q[SEG_W-1:0], 2'b00});
         end
         DONE: begin
            bus_io.refill_valid_o = 1'b1;
            bus_io.refill_vpn_o   = vpn_q;
            bus_io.refill_pte_o   = pte_q;
            bus_io.refill_level_o = level_q;
            bus_io.fault_o        = fault_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_itlb_ptw.sv
// Randomized and directed stimulus for itlb_ptw, checked every cycle against a
// transaction-level Sv32 walk model.
module tb_itlb_ptw;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] satp = '0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   itlb_ptw_if bus();

   itlb_ptw dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .satp_i (satp),
      .flush_i(flush),
      .bus_io (bus)
   );

   // Expectations published by the driver, consumed by the compare process.
   logic [33:0] exp_addr_q[$];
   bit          exp_ref_on = 0;
   logic [19:0] exp_vpn = '0;
   logic [31:0] exp_pte = '0;
   logic        exp_lvl = 0;
   logic        exp_flt = 0;
   int          ready_chk = 0;
   bit          lat_chk = 0;
   int          lat_meas = 0;
   int          lat_exp = 0;
   int          tmo_cnt = 0;

   int total = 0;
   int bad = 0;

   // Sv32 walk outcome from the page-table rules.
   function automatic void model(input logic [31:0] s, va, p1, p2,
                                 output int nreq, output logic [33:0] a1, a2,
                                 output logic [31:0] pte, output logic lvl, flt);
      nreq = 0; a1 = '0; a2 = '0; pte = '0; lvl = 0; flt = 1;
      if (!s[31]) return;
      nreq = 1;
      a1 = 34'(s[21:0]) * 34'd4096 + 34'(va[31:22]) * 34'd4;
      if (!p1[0] || (!p1[1] && p1[2])) return;
      if (p1[1] || p1[3]) begin
         if (p1[19:10] == 10'd0 && p1[3]) begin flt = 0; lvl = 1; pte = p1; end
         return;
      end
      nreq = 2;
      a2 = 34'(p1[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4;
      if (!p2[0] || (!p2[1] && p2[2]) || !p2[3]) return;
      flt = 0; pte = p2;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Compare process: model pins, then every falling edge.
   initial begin : compare
      int n; logic [33:0] a1, a2; logic [31:0] pte; logic lvl, flt; int tmo_seen;
      tmo_seen = 0;
      model(32'h8000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_544B, n, a1, a2, pte, lvl, flt);
      chk("pin_2lvl_a1", 64'(a1), 64'h10004);
      chk("pin_2lvl_a2", 64'(a2), 64'h2000C);
      chk("pin_2lvl_res", 64'({n[1:0], pte, lvl, flt}), 64'({2'd2, 32'h1544B, 1'b0, 1'b0}));
      model(32'h8000_0010, 32'h0040_3123, 32'h0010_004B, 32'h0, n, a1, a2, pte, lvl, flt);
      chk("pin_mega", 64'({n[1:0], pte, lvl, flt}), 64'({2'd1, 32'h10004B, 1'b1, 1'b0}));
      model(32'h8000_0010, 32'h0040_3123, 32'h0010_044B, 32'h0, n, a1, a2, pte, lvl, flt);
      chk("pin_misalign", 64'({n[1:0], pte, flt}), 64'({2'd1, 32'h0, 1'b1}));
      model(32'h8000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_5447, n, a1, a2, pte, lvl, flt);
      chk("pin_noexec", 64'({n[1:0], pte, flt}), 64'({2'd2, 32'h0, 1'b1}));
      model(32'h0000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_544B, n, a1, a2, pte, lvl, flt);
      chk("pin_bare", 64'({n[1:0], pte, flt}), 64'({2'd0, 32'h0, 1'b1}));
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk("reset_ctl", 64'({bus.miss_ready_o, bus.mem_req_valid_o, bus.refill_valid_o,
                                  bus.fault_o, bus.refill_level_o}), 64'(5'b10000));
            chk("reset_addr", 64'(bus.mem_req_addr_o), 64'd0);
            chk("reset_refill", 64'({bus.refill_vpn_o, bus.refill_pte_o}), 64'd0);
         end else begin
            if (bus.mem_req_valid_o) begin
               chk("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
               if (exp_addr_q.size() != 0) chk("req_addr", 64'(bus.mem_req_addr_o), 64'(exp_addr_q[0]));
            end
            if (bus.refill_valid_o) begin
               chk("refill_expected", 64'(exp_ref_on), 64'd1);
               if (exp_ref_on) begin
                  chk("refill_vpn", 64'(bus.refill_vpn_o), 64'(exp_vpn));
                  chk("refill_pte", 64'(bus.refill_pte_o), 64'(exp_pte));
                  chk("refill_fault", 64'(bus.fault_o), 64'(exp_flt));
                  if (!exp_flt) chk("refill_level", 64'(bus.refill_level_o), 64'(exp_lvl));
               end
            end
            if (ready_chk != 0) chk("miss_ready", 64'(bus.miss_ready_o), 64'(ready_chk == 1));
            if (lat_chk) chk("latency", 64'(lat_meas), 64'(lat_exp));
         end
         if (tmo_cnt != tmo_seen) begin
            chk("timeout", 64'(tmo_cnt), 64'(tmo_seen));
            tmo_seen = tmo_cnt;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic miss_accept(input logic [31:0] va, output int acc);
      int n;
      n = 0;
      bus.miss_valid_i = 1'b1;
      bus.miss_vaddr_i = va;
      while (!bus.miss_ready_o && n < 20) begin step(); n++; end
      if (!bus.miss_ready_o) tmo_cnt++;
      acc = cyc;
      step();
      bus.miss_valid_i = 1'b0;
      bus.miss_vaddr_i = $urandom;
      satp = $urandom;
   endtask

   task automatic do_req(input int stall);
      int n;
      n = 0;
      while (!bus.mem_req_valid_o && n < 20) begin step(); n++; end
      if (!bus.mem_req_valid_o) tmo_cnt++;
      for (int i = 0; i < stall; i++) step();
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
   endtask

   task automatic do_rsp(input int dly, input logic [31:0] d);
      for (int i = 0; i < dly; i++) step();
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = d;
      step();
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i  = $urandom;
   endtask

   task automatic run_walk(input logic [31:0] s, va, p1, p2,
                           input int rq_st, rs_dl, rf_st, input bit fl_done);
      int nreq, acc, lat, n; logic [33:0] a1, a2; logic [31:0] pte; logic lvl, flt;
      model(s, va, p1, p2, nreq, a1, a2, pte, lvl, flt);
      exp_addr_q.delete();
      if (nreq > 0) exp_addr_q.push_back(a1);
      if (nreq > 1) exp_addr_q.push_back(a2);
      exp_vpn = va[31:12]; exp_pte = pte; exp_lvl = lvl; exp_flt = flt; exp_ref_on = 1;
      satp = s;
      miss_accept(va, acc);
      lat = 1;
      for (int i = 0; i < nreq; i++) begin
         do_req(rq_st);
         do_rsp(rs_dl, (i == 0) ? p1 : p2);
         lat += 2 + rq_st + rs_dl;
      end
      n = 0;
      while (!bus.refill_valid_o && n < 40) begin step(); n++; end
      if (!bus.refill_valid_o) tmo_cnt++;
      lat_meas = cyc - acc; lat_exp = lat; lat_chk = 1;
      step();
      lat_chk = 0;
      if (fl_done) begin
         flush = 1'b1; bus.refill_ready_i = 1'b1;
         step();
         flush = 1'b0; bus.refill_ready_i = 1'b0;
      end else begin
         for (int i = 1; i < rf_st; i++) step();
         bus.refill_ready_i = 1'b1;
         step();
         bus.refill_ready_i = 1'b0;
      end
      exp_ref_on = 0; ready_chk = 1;
      step();
      ready_chk = 0;
   endtask

   function automatic logic [31:0] gen_pte(input int lvl);
      logic [31:0] p;
      p = $urandom;
      case ($urandom_range(0, 5))
         0, 1: p[3:0] = 4'b0001;
         2, 3: begin
            p[0] = 1'b1; p[3] = 1'b1; p[2] = p[1] & p[2];
            if (lvl == 1 && $urandom_range(0, 3) != 0) p[19:10] = '0;
         end
         default: ;
      endcase
      return p;
   endfunction

   initial begin : driver
      int acc;
      bus.miss_valid_i = 0; bus.miss_vaddr_i = '0; bus.mem_req_ready_i = 0;
      bus.mem_rsp_valid_i = 0; bus.mem_rsp_data_i = '0; bus.refill_ready_i = 0;
      repeat (3) step();
      rstn = 1'b1;
      step();

      // Reference walks: two-level, megapage, misaligned, no-exec, bare.
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_544B, 0, 0, 1, 0);
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0010_004B, 32'h0, 0, 0, 1, 0);
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0010_044B, 32'h0, 0, 0, 1, 0);
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_5447, 0, 0, 1, 0);
      run_walk(32'h0000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_544B, 0, 0, 1, 0);
      // Request backpressure 4 cycles, refill backpressure 3 cycles.
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0000_8001, 32'h0001_544B, 4, 1, 3, 0);
      // Flush in DONE drops the refill.
      run_walk(32'h8000_0010, 32'h0040_3123, 32'h0010_004B, 32'h0, 0, 0, 1, 1);

      // Flush in L1_RSP, response two cycles later is drained.
      satp = 32'h8000_0010; exp_addr_q.delete(); exp_addr_q.push_back(34'h10004); exp_ref_on = 0;
      miss_accept(32'h0040_3123, acc);
      do_req(0);
      flush = 1'b1; step(); flush = 1'b0;
      ready_chk = 2; step(); ready_chk = 0;
      do_rsp(0, 32'h0010_004B);
      ready_chk = 1; step(); step(); ready_chk = 0;

      // Flush in L1_REQ without acceptance: straight back to idle.
      satp = 32'h8000_0010; exp_addr_q.push_back(34'h10004);
      miss_accept(32'h0040_3123, acc);
      flush = 1'b1; step(); flush = 1'b0; exp_addr_q.delete();
      ready_chk = 1; step(); ready_chk = 0;

      // Flush in L1_REQ with acceptance: must drain one response.
      satp = 32'h8000_0010; exp_addr_q.push_back(34'h10004);
      miss_accept(32'h0040_3123, acc);
      flush = 1'b1; bus.mem_req_ready_i = 1'b1; step();
      flush = 1'b0; bus.mem_req_ready_i = 1'b0; exp_addr_q.delete();
      ready_chk = 2; step(); ready_chk = 0;
      do_rsp(0, 32'h0010_004B);
      ready_chk = 1; step(); ready_chk = 0;

      // Flush in L0_RSP together with the response: idle, no drain.
      satp = 32'h8000_0010; exp_addr_q.push_back(34'h10004); exp_addr_q.push_back(34'h2000C);
      miss_accept(32'h0040_3123, acc);
      do_req(0); do_rsp(0, 32'h0000_8001); do_req(0);
      flush = 1'b1; bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 32'h0001_544B;
      step();
      flush = 1'b0; bus.mem_rsp_valid_i = 1'b0;
      ready_chk = 1; step(); ready_chk = 0;

      // Reset during L0_RSP, then a stray late response.
      satp = 32'h8000_0010; exp_addr_q.push_back(34'h10004); exp_addr_q.push_back(34'h2000C);
      miss_accept(32'h0040_3123, acc);
      do_req(0); do_rsp(0, 32'h0000_8001); do_req(0);
      rstn = 1'b0; exp_addr_q.delete();
      step();
      rstn = 1'b1; ready_chk = 1;
      step();
      do_rsp(0, 32'h0001_544B);
      step(); ready_chk = 0;

      for (int it = 0; it < 40; it++) begin
         logic [31:0] s, va, p1, p2;
         if ($urandom_range(0, 3) == 0) begin
            ready_chk = 1;
            do_rsp(0, $urandom);
            step();
            ready_chk = 0;
         end
         s = $urandom;
         s[31] = ($urandom_range(0, 7) != 0);
         va = $urandom;
         p1 = gen_pte(1);
         p2 = gen_pte(0);
         run_walk(s, va, p1, p2, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      end

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
